// File: rtl/lc3_execute.sv
// LC-3 execute stage: ALU/LEA/BR evaluation and NZP ownership. Result is registered one edge
// after the EXEC cycle and held until writeback takes it. dec_ready depends combinationally on wb_ready while holding.
module lc3_execute #(
    parameter int         WIDTH  = 16,
    parameter logic [2:0] CC_RST = 3'b010
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             dec_valid,
    output logic             dec_ready,
    input  logic [WIDTH-1:0] instr,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] sr1_val,
    input  logic [WIDTH-1:0] sr2_val,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic             wb_we,
    output logic [2:0]       wb_dr,
    output logic [WIDTH-1:0] wb_data,
    output logic             br_taken,
    output logic [WIDTH-1:0] br_target,
    output logic             illegal,
    output logic [2:0]       cc_nzp
);

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    state_t           state;
    logic [WIDTH-1:0] instr_q;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] sr1_q;
    logic [WIDTH-1:0] sr2_q;

    logic [3:0]       op;
    logic [WIDTH-1:0] imm5;
    logic [WIDTH-1:0] off9;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] res_data;
    logic [WIDTH-1:0] res_target;
    logic             res_we;
    logic             res_taken;
    logic             res_illegal;
    logic [2:0]       cc_wb;

    assign dec_ready = (state == IDLE) || ((state == HOLD) && wb_ready);

    always_comb begin
        op          = instr_q[15:12];
        imm5        = {{(WIDTH-5){instr_q[4]}}, instr_q[4:0]};
        off9        = {{(WIDTH-9){instr_q[8]}}, instr_q[8:0]};
        opnd        = instr_q[5] ? imm5 : sr2_q;
        res_target  = pc_q + off9;
        res_data    = '0;
        res_we      = 1'b0;
        res_taken   = 1'b0;
        res_illegal = 1'b0;
        case (op)
            4'b0001: begin
                res_data = sr1_q + opnd;
                res_we   = 1'b1;
            end
            4'b0101: begin
                res_data = sr1_q & opnd;
                res_we   = 1'b1;
            end
            4'b1001: begin
                res_data = ~sr1_q;
                res_we   = 1'b1;
            end
            4'b1110: begin
                res_data = res_target;
                res_we   = 1'b1;
            end
            // BR reads the live CC register; any preceding writer has already retired.
            4'b0000: res_taken = |(instr_q[11:9] & cc_nzp);
            default: res_illegal = 1'b1;
        endcase
    end

    always_comb begin
        cc_wb = 3'b001;
        if (wb_data[WIDTH-1]) begin
            cc_wb = 3'b100;
        end else if (wb_data == '0) begin
            cc_wb = 3'b010;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            wb_valid  <= 1'b0;
            wb_we     <= 1'b0;
            wb_dr     <= 3'b000;
            wb_data   <= '0;
            br_taken  <= 1'b0;
            br_target <= '0;
            illegal   <= 1'b0;
            cc_nzp    <= CC_RST;
        end else begin
            case (state)
                IDLE: begin
                    if (dec_valid && dec_ready) begin
                        instr_q <= instr;
                        pc_q    <= pc;
                        sr1_q   <= sr1_val;
                        sr2_q   <= sr2_val;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    wb_valid  <= 1'b1;
                    wb_we     <= res_we;
                    wb_dr     <= instr_q[11:9];
                    wb_data   <= res_data;
                    br_taken  <= res_taken;
                    br_target <= res_target;
                    illegal   <= res_illegal;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (wb_ready) begin
                        wb_valid <= 1'b0;
                        if (wb_we) begin
                            cc_nzp <= cc_wb;
                        end
                        if (dec_valid) begin
                            instr_q <= instr;
                            pc_q    <= pc;
                            sr1_q   <= sr1_val;
                            sr2_q   <= sr2_val;
                            state   <= EXEC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_execute.sv
// Bench for lc3_execute: transaction-level model checked every cycle plus directed literal checks.
module tb_lc3_execute;

    logic        clock = 1'b0;
    logic        reset;
    logic        dec_valid;
    logic        dec_ready;
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] sr1_val;
    logic [15:0] sr2_val;
    logic        wb_valid;
    logic        wb_ready;
    logic        wb_we;
    logic [2:0]  wb_dr;
    logic [15:0] wb_data;
    logic        br_taken;
    logic [15:0] br_target;
    logic        illegal;
    logic [2:0]  cc_nzp;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    lc3_execute #(.WIDTH(16), .CC_RST(3'b010)) dut (
        .clock(clock), .reset(reset), .dec_valid(dec_valid), .dec_ready(dec_ready),
        .instr(instr), .pc(pc), .sr1_val(sr1_val), .sr2_val(sr2_val),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_we(wb_we), .wb_dr(wb_dr),
        .wb_data(wb_data), .br_taken(br_taken), .br_target(br_target),
        .illegal(illegal), .cc_nzp(cc_nzp)
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    typedef struct packed {
        logic        we;
        logic [2:0]  dr;
        logic [15:0] data;
        logic        taken;
        logic [15:0] target;
        logic        ill;
    } res_t;

    function automatic logic [2:0] nzp_of(input logic [15:0] v);
        if (v[15]) return 3'b100;
        if (v == 16'h0000) return 3'b010;
        return 3'b001;
    endfunction

    // Architectural meaning of each opcode, in signed integer arithmetic.
    function automatic res_t model_exec(input logic [15:0] i, input logic [15:0] p,
                                        input logic [15:0] a, input logic [15:0] b,
                                        input logic [2:0] cc);
        res_t r;
        int imm5;
        int off9;
        int src2;
        imm5 = int'(i[4:0]) - (i[4] ? 32 : 0);
        off9 = int'(i[8:0]) - (i[8] ? 512 : 0);
        src2 = i[5] ? imm5 : int'(b);
        r.we = 1'b0;
        r.dr = i[11:9];
        r.data = 16'h0000;
        r.taken = 1'b0;
        r.target = 16'(int'(p) + off9);
        r.ill = 1'b0;
        case (int'(i[15:12]))
            1:  begin r.we = 1'b1; r.data = 16'(int'(a) + src2); end
            5:  begin r.we = 1'b1; r.data = a & 16'(src2); end
            9:  begin r.we = 1'b1; r.data = 16'(65535 - int'(a)); end
            14: begin r.we = 1'b1; r.data = r.target; end
            0:  r.taken = (i[11] && cc == 3'b100) || (i[10] && cc == 3'b010) ||
                          (i[9] && cc == 3'b001);
            default: r.ill = 1'b1;
        endcase
        return r;
    endfunction

    bit         m_have = 1'b0;
    int         m_age = 0;
    res_t       m_res;
    logic [2:0] m_cc = 3'b010;

    always @(negedge clock) begin
        bit exp_wbv;
        bit exp_rdy;
        bit fire_wb;
        bit fire_dec;
        exp_wbv = m_have && (m_age >= 1);
        exp_rdy = !m_have || (exp_wbv && wb_ready);
        if (!reset) begin
            chk("m_wb_valid", wb_valid, exp_wbv);
            chk("m_dec_ready", dec_ready, exp_rdy);
            chk("m_cc_nzp", cc_nzp, m_cc);
            if (exp_wbv) begin
                chk("m_wb_we", wb_we, m_res.we);
                chk("m_wb_dr", wb_dr, m_res.dr);
                chk("m_wb_data", wb_data, m_res.data);
                chk("m_br_taken", br_taken, m_res.taken);
                chk("m_br_target", br_target, m_res.target);
                chk("m_illegal", illegal, m_res.ill);
            end
        end
        if (reset) begin
            m_have = 1'b0;
            m_cc   = 3'b010;
        end else begin
            fire_wb  = exp_wbv && wb_ready;
            fire_dec = dec_valid && exp_rdy;
            if (fire_wb) begin
                if (m_res.we) m_cc = nzp_of(m_res.data);
                m_have = 1'b0;
            end
            if (m_have) m_age++;
            if (fire_dec) begin
                m_res  = model_exec(instr, pc, sr1_val, sr2_val, m_cc);
                m_have = 1'b1;
                m_age  = 0;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [15:0] i, input logic [15:0] p,
                         input logic [15:0] a, input logic [15:0] b);
        bit got;
        step();
        instr = i; pc = p; sr1_val = a; sr2_val = b;
        dec_valid = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clock);
            got = dec_ready;
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: dec_ready stayed 0, required 1");
        end
        step();
        dec_valid = 1'b0;
    endtask

    task automatic wait_result();
        @(negedge clock);
        chk("lat_exec_wb_valid", wb_valid, 1'b0);
        @(negedge clock);
        chk("lat_hold_wb_valid", wb_valid, 1'b1);
    endtask

    task automatic consume();
        step();
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1; dec_valid = 1'b0; wb_ready = 1'b0;
        instr = 16'h0; pc = 16'h0; sr1_val = 16'h0; sr2_val = 16'h0;
        step();
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_dec_ready", dec_ready, 1'b1);
        chk("rst_cc", cc_nzp, 3'b010);
        chk("rst_wb_data", wb_data, 16'h0);
        chk("rst_br_target", br_target, 16'h0);

        issue(16'h1283, 16'h3000, 16'd5, 16'd7);
        wait_result();
        chk("add_reg_dr", wb_dr, 3'd1);
        chk("add_reg_data", wb_data, 16'd12);
        chk("add_reg_we", wb_we, 1'b1);
        consume();
        chk("add_reg_cc", cc_nzp, 3'b001);

        issue(16'h12BD, 16'h3001, 16'd2, 16'h0);
        wait_result();
        chk("add_imm_data", wb_data, 16'hFFFF);
        consume();
        chk("add_imm_cc", cc_nzp, 3'b100);

        issue(16'h5283, 16'h3002, 16'h00F0, 16'h0F00);
        wait_result();
        chk("and_data", wb_data, 16'h0000);
        consume();
        chk("and_cc", cc_nzp, 3'b010);

        issue(16'h967F, 16'h3003, 16'h1234, 16'h0);
        wait_result();
        chk("not_dr", wb_dr, 3'd3);
        chk("not_data", wb_data, 16'hEDCB);
        consume();
        chk("not_cc", cc_nzp, 3'b100);

        issue(16'h0805, 16'h3001, 16'h0, 16'h0);
        wait_result();
        chk("br_n_taken", br_taken, 1'b1);
        chk("br_n_target", br_target, 16'h3006);
        chk("br_n_we", wb_we, 1'b0);
        consume();
        chk("br_cc_kept", cc_nzp, 3'b100);

        issue(16'h0205, 16'h3001, 16'h0, 16'h0);
        wait_result();
        chk("br_p_not_taken", br_taken, 1'b0);
        consume();

        issue(16'h0000, 16'h3001, 16'h0, 16'h0);
        wait_result();
        chk("br_000_never", br_taken, 1'b0);
        consume();

        issue(16'h0E00, 16'h3001, 16'h0, 16'h0);
        wait_result();
        chk("br_111_always", br_taken, 1'b1);
        consume();

        issue(16'hE9FE, 16'h3010, 16'h0, 16'h0);
        wait_result();
        chk("lea_dr", wb_dr, 3'd4);
        chk("lea_data", wb_data, 16'h300E);
        consume();
        chk("lea_cc", cc_nzp, 3'b001);

        // Backpressure, then a BR handed over on the same edge that retires a negative ADD.
        issue(16'h12BD, 16'h3020, 16'd2, 16'h0);
        wait_result();
        step();
        instr = 16'h0805; pc = 16'h3001; sr1_val = 16'h0; sr2_val = 16'h0;
        dec_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk("bp_dec_ready", dec_ready, 1'b0);
            chk("bp_wb_valid", wb_valid, 1'b1);
            chk("bp_wb_data", wb_data, 16'hFFFF);
            step();
        end
        wb_ready = 1'b1;
        @(negedge clock);
        chk("handoff_dec_ready", dec_ready, 1'b1);
        step();
        wb_ready = 1'b0;
        dec_valid = 1'b0;
        @(negedge clock);
        chk("handoff_wb_valid_low", wb_valid, 1'b0);
        chk("handoff_cc", cc_nzp, 3'b100);
        @(negedge clock);
        chk("handoff_wb_valid_high", wb_valid, 1'b1);
        chk("handoff_br_taken", br_taken, 1'b1);
        consume();

        issue(16'h1283, 16'h3030, 16'd5, 16'd7);
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("rst_exec_wb_valid", wb_valid, 1'b0);
        chk("rst_exec_dec_ready", dec_ready, 1'b1);
        chk("rst_exec_cc", cc_nzp, 3'b010);
        chk("rst_exec_wb_data", wb_data, 16'h0);

        issue(16'h3000, 16'h3040, 16'h1111, 16'h2222);
        wait_result();
        chk("ill_flag", illegal, 1'b1);
        chk("ill_we", wb_we, 1'b0);
        chk("ill_data", wb_data, 16'h0);
        chk("ill_taken", br_taken, 1'b0);
        consume();
        chk("ill_cc", cc_nzp, 3'b010);

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
